// File: rtl/sel_arb_pkg.sv
// ---------------------------------------------------------------------------
// sel_arb_pkg
// Shared definitions for the code-select mux round-robin arbiter.
//   NUM_REQ        : number of requesters sharing the mux
//   SEL_W          : width of the mux select
//   state_t        : arbiter state (IDLE / BUSY)
//   onehot_to_idx  : encodes a one-hot grant vector into a select index
// ---------------------------------------------------------------------------
package sel_arb_pkg;

  localparam int NUM_REQ = 4;
  localparam int SEL_W   = 2;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // OR-reduction encoder: correct for any vector with at most one bit set.
  function automatic logic [SEL_W-1:0] onehot_to_idx(input logic [NUM_REQ-1:0] onehot);
    logic [SEL_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (onehot[i]) idx = idx | SEL_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/sel_rr_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational round-robin search. Scans iStart, iStart+1, ... (mod NUM_REQ)
// and returns the first requesting index, optionally skipping one index.
//   iReq     : request vector
//   iStart   : first index examined
//   iExclEn  : when 1, iExclIdx is never selected
//   iExclIdx : index to skip (the current owner)
//   oFound   : some eligible requester exists
//   oIdx     : chosen index (iStart when nothing is found)
// ---------------------------------------------------------------------------
module rr_pick
  import sel_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] iReq,
  input  logic [SEL_W-1:0]   iStart,
  input  logic               iExclEn,
  input  logic [SEL_W-1:0]   iExclIdx,
  output logic               oFound,
  output logic [SEL_W-1:0]   oIdx
);

  logic [SEL_W-1:0]   w_cand_idx [NUM_REQ];
  logic [NUM_REQ-1:0] w_cand_ok;

  // Candidate gi is the index gi steps after the start; the adder wraps
  // naturally because SEL_W bits cover exactly NUM_REQ indices.
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
      assign w_cand_idx[gi] = iStart + SEL_W'(gi);
      assign w_cand_ok[gi]  = iReq[w_cand_idx[gi]] &&
                              !(iExclEn && (w_cand_idx[gi] == iExclIdx));
    end
  endgenerate

  // Walk from the farthest candidate down so the nearest eligible one wins.
  always_comb begin
    oFound = 1'b0;
    oIdx   = iStart;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (w_cand_ok[i]) begin
        oFound = 1'b1;
        oIdx   = w_cand_idx[i];
      end
    end
  end

endmodule

// File: rtl/sel_rr_arbiter.sv
// ---------------------------------------------------------------------------
// sel_rr_arbiter
// Round-robin arbiter in front of the 4:1 code-select mux. Grants one of four
// requesters, bounding each tenure to MAX_HOLD cycles while others wait.
//   iClk    : clock, rising edge
//   iRst_n  : asynchronous active-low reset
//   iReq    : per-source request
//   iLock   : (only with SEL_RR_ARBITER_LOCK_EN) suppresses forced rotation
//   oGrant  : registered one-hot grant, zero when idle
//   oSel    : registered mux select, index of the granted source
//   oValid  : high while oGrant is non-zero
// Optional feature macro: SEL_RR_ARBITER_LOCK_EN
// ---------------------------------------------------------------------------
module sel_rr_arbiter
  import sel_arb_pkg::*;
#(
  parameter int MAX_HOLD = 4,
  parameter int CNT_W    = 3
) (
  input  logic               iClk,
  input  logic               iRst_n,
  input  logic [NUM_REQ-1:0] iReq,
`ifdef SEL_RR_ARBITER_LOCK_EN
  input  logic               iLock,
`endif
  output logic [NUM_REQ-1:0] oGrant,
  output logic [SEL_W-1:0]   oSel,
  output logic               oValid
);

  state_t             r_state;
  logic [SEL_W-1:0]   r_ptr;
  logic [CNT_W-1:0]   r_cnt;
  logic [NUM_REQ-1:0] r_grant;
  logic [SEL_W-1:0]   r_sel;

  state_t             w_state_next;
  logic [SEL_W-1:0]   w_ptr_next;
  logic [CNT_W-1:0]   w_cnt_next;
  logic [NUM_REQ-1:0] w_grant_next;
  logic [SEL_W-1:0]   w_sel_next;

  logic               w_found;
  logic [SEL_W-1:0]   w_pick_idx;
  logic [NUM_REQ-1:0] w_pick_onehot;
  logic [SEL_W-1:0]   w_owner;
  logic               w_cnt_at_max;
  logic               w_lock;

`ifdef SEL_RR_ARBITER_LOCK_EN
  assign w_lock = iLock;
`else
  assign w_lock = 1'b0;
`endif

  // While BUSY, r_sel is the owner and r_ptr is owner+1, so a search from
  // r_ptr that skips the owner yields the next requester after the owner.
  assign w_owner = r_sel;

  rr_pick u_rr_pick (
    .iReq     (iReq),
    .iStart   (r_ptr),
    .iExclEn  (r_state == BUSY),
    .iExclIdx (w_owner),
    .oFound   (w_found),
    .oIdx     (w_pick_idx)
  );

  assign w_pick_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << w_pick_idx;
  assign w_cnt_at_max  = (r_cnt == CNT_W'(MAX_HOLD));

  always_comb begin
    w_state_next = r_state;
    w_ptr_next   = r_ptr;
    w_cnt_next   = r_cnt;
    w_grant_next = r_grant;

    case (r_state)
      IDLE: begin
        w_grant_next = '0;
        if (w_found) begin
          w_state_next = BUSY;
          w_grant_next = w_pick_onehot;
          w_ptr_next   = w_pick_idx + SEL_W'(1);
          w_cnt_next   = CNT_W'(1);
        end
      end
      BUSY: begin
        if (!iReq[w_owner]) begin
          if (w_found) begin
            // Release with others waiting: hand over without an idle bubble.
            w_grant_next = w_pick_onehot;
            w_ptr_next   = w_pick_idx + SEL_W'(1);
            w_cnt_next   = CNT_W'(1);
          end else begin
            w_state_next = IDLE;
            w_grant_next = '0;
            w_cnt_next   = '0;
          end
        end else if (w_cnt_at_max && w_found && !w_lock) begin
          // Tenure expired while someone else waits: force rotation.
          w_grant_next = w_pick_onehot;
          w_ptr_next   = w_pick_idx + SEL_W'(1);
          w_cnt_next   = CNT_W'(1);
        end else if (!w_cnt_at_max) begin
          w_cnt_next = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_next = IDLE;
        w_grant_next = '0;
      end
    endcase
  end

  // The select only moves when a grant is issued; in IDLE it keeps its value.
  assign w_sel_next = (|w_grant_next) ? onehot_to_idx(w_grant_next) : r_sel;

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_cnt   <= '0;
      r_grant <= '0;
      r_sel   <= '0;
    end else begin
      r_state <= w_state_next;
      r_ptr   <= w_ptr_next;
      r_cnt   <= w_cnt_next;
      r_grant <= w_grant_next;
      r_sel   <= w_sel_next;
    end
  end

  assign oGrant = r_grant;
  assign oSel   = r_sel;
  assign oValid = |r_grant;

endmodule

// File: tb/tb_sel_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sel_rr_arbiter
// Self-checking bench for sel_rr_arbiter. Each step drives a request vector,
// pushes the reference model's expected outputs to a scoreboard queue, and a
// monitor pops and compares after the following clock edge. Scenario tasks
// add their own directed checks on top.
// ---------------------------------------------------------------------------
module tb_sel_rr_arbiter;
  import sel_arb_pkg::*;

  localparam int MAX_HOLD = 4;

  logic       iClk;
  logic       iRst_n;
  logic [3:0] iReq;
  logic [3:0] oGrant;
  logic [1:0] oSel;
  logic       oValid;
  logic       tb_lock;
`ifdef SEL_RR_ARBITER_LOCK_EN
  logic       iLock;
  assign iLock = tb_lock;
`endif

  sel_rr_arbiter #(.MAX_HOLD(MAX_HOLD), .CNT_W(3)) dut (
    .iClk   (iClk),
    .iRst_n (iRst_n),
    .iReq   (iReq),
`ifdef SEL_RR_ARBITER_LOCK_EN
    .iLock  (iLock),
`endif
    .oGrant (oGrant),
    .oSel   (oSel),
    .oValid (oValid)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  int checks   = 0;
  int failures = 0;
  int txn      = 0;

  typedef struct packed {
    logic [3:0] req;
    logic [3:0] grant;
    logic [1:0] sel;
    logic       valid;
  } exp_t;
  exp_t sb_q[$];

  // Reference model state
  bit       m_busy;
  int       m_owner;
  int       m_ptr;
  int       m_cnt;
  int       m_sel;

  task automatic model_reset();
    m_busy = 0; m_owner = 0; m_ptr = 0; m_cnt = 0; m_sel = 0;
  endtask

  task automatic model_step(input logic [3:0] req, input logic lock);
    bit found;
    int nxt;
    found = 0;
    nxt   = 0;
    if (!m_busy) begin
      for (int i = 0; i < 4; i++)
        if (!found && req[(m_ptr + i) % 4]) begin found = 1; nxt = (m_ptr + i) % 4; end
    end else begin
      for (int i = 1; i < 4; i++)
        if (!found && req[(m_owner + i) % 4]) begin found = 1; nxt = (m_owner + i) % 4; end
    end
    if (!m_busy) begin
      if (found) begin m_busy = 1; m_owner = nxt; m_cnt = 1; m_ptr = (nxt + 1) % 4; end
    end else if (!req[m_owner]) begin
      if (found) begin m_owner = nxt; m_cnt = 1; m_ptr = (nxt + 1) % 4; end
      else begin m_busy = 0; m_cnt = 0; end
    end else if (m_cnt == MAX_HOLD && found && !lock) begin
      m_owner = nxt; m_cnt = 1; m_ptr = (nxt + 1) % 4;
    end else if (m_cnt < MAX_HOLD) begin
      m_cnt = m_cnt + 1;
    end
    if (m_busy) m_sel = m_owner;
  endtask

  // Drive one cycle of stimulus and queue what the model expects after the edge.
  // Returns 2 time units after the edge, once the monitor has compared.
  task automatic step(input logic [3:0] req);
    exp_t e;
    @(negedge iClk);
    iReq = req;
    model_step(req, tb_lock);
    e.req   = req;
    e.grant = m_busy ? (4'b0001 << m_owner) : 4'b0000;
    e.sel   = 2'(m_sel);
    e.valid = m_busy;
    sb_q.push_back(e);
    @(posedge iClk);
    #2;
  endtask

  // Scoreboard monitor
  always @(posedge iClk) begin
    #1;
    if (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      txn++;
      $display("txn %0d req=%b grant=%b sel=%0d valid=%0b", txn, e.req, oGrant, oSel, oValid);
      checks++;
      if (oGrant !== e.grant) begin
        failures++;
        $display("FAIL sb_grant txn=%0d got=%b exp=%b", txn, oGrant, e.grant);
      end
      checks++;
      if (oSel !== e.sel) begin
        failures++;
        $display("FAIL sb_sel txn=%0d got=%0d exp=%0d", txn, oSel, e.sel);
      end
      checks++;
      if (oValid !== e.valid) begin
        failures++;
        $display("FAIL sb_valid txn=%0d got=%0b exp=%0b", txn, oValid, e.valid);
      end
      checks++;
      if ($countones(oGrant) > 1) begin
        failures++;
        $display("FAIL onehot txn=%0d got=%b exp=at_most_one_bit", txn, oGrant);
      end
    end
  end

  task automatic test_reset();
    iRst_n  = 1'b0;
    iReq    = 4'b0000;
    tb_lock = 1'b0;
    model_reset();
    repeat (2) @(posedge iClk);
    #1;
    checks++;
    if (oGrant !== 4'b0000 || oSel !== 2'b00 || oValid !== 1'b0) begin
      failures++;
      $display("FAIL reset_state got=%b/%0d/%0b exp=0000/0/0", oGrant, oSel, oValid);
    end
    @(negedge iClk);
    iRst_n = 1'b1;
    step(4'b0000);
  endtask

  task automatic test_first_grant();
    step(4'b0100);
    checks++;
    if (oGrant !== 4'b0100 || oSel !== 2'b10 || oValid !== 1'b1) begin
      failures++;
      $display("FAIL first_grant got=%b/%0d/%0b exp=0100/2/1", oGrant, oSel, oValid);
    end
    step(4'b0000);
    checks++;
    if (oValid !== 1'b0 || oSel !== 2'b10) begin
      failures++;
      $display("FAIL idle_sel_hold got=%0b/%0d exp=0/2", oValid, oSel);
    end
    // Search must now start at 3, so 3 beats 0 and 1.
    step(4'b1011);
    checks++;
    if (oGrant !== 4'b1000) begin
      failures++;
      $display("FAIL ptr_after_grant got=%b exp=1000", oGrant);
    end
  endtask

  task automatic test_rotation();
    logic [3:0] exp_g;
    step(4'b0000);
    // Idle with ptr = 0 after owner 3: full load rotates 0,1,2,3,0 every 4 cycles.
    for (int n = 0; n < 20; n++) begin
      step(4'b1111);
      exp_g = 4'b0001 << ((n / MAX_HOLD) % 4);
      checks++;
      if (oGrant !== exp_g) begin
        failures++;
        $display("FAIL rotation cycle=%0d got=%b exp=%b", n, oGrant, exp_g);
      end
    end
  endtask

  task automatic test_handover();
    step(4'b0000);
    step(4'b0010);
    step(4'b1011);
    step(4'b1001);
    checks++;
    if (oGrant !== 4'b1000 || oSel !== 2'b11 || oValid !== 1'b1) begin
      failures++;
      $display("FAIL handover got=%b/%0d/%0b exp=1000/3/1", oGrant, oSel, oValid);
    end
  endtask

  task automatic test_sole_hold();
    step(4'b0000);
    for (int n = 0; n < 20; n++) begin
      step(4'b0100);
      checks++;
      if (oGrant !== 4'b0100) begin
        failures++;
        $display("FAIL sole_hold cycle=%0d got=%b exp=0100", n, oGrant);
      end
    end
    step(4'b0101);
    checks++;
    if (oGrant !== 4'b0001 || oSel !== 2'b00) begin
      failures++;
      $display("FAIL sole_then_rotate got=%b/%0d exp=0001/0", oGrant, oSel);
    end
  endtask

  task automatic test_async_reset();
    step(4'b0000);
    step(4'b0001);   // owner 0, ptr becomes 1
    step(4'b0001);
    #1;              // mid-cycle, well before the next edge
    iRst_n = 1'b0;
    #1;
    checks++;
    if (oGrant !== 4'b0000 || oSel !== 2'b00 || oValid !== 1'b0) begin
      failures++;
      $display("FAIL async_reset got=%b/%0d/%0b exp=0000/0/0", oGrant, oSel, oValid);
    end
    model_reset();
    @(negedge iClk);
    iRst_n = 1'b1;
    step(4'b0011);
    checks++;
    if (oGrant !== 4'b0001) begin
      failures++;
      $display("FAIL ptr_reset got=%b exp=0001", oGrant);
    end
  endtask

`ifdef SEL_RR_ARBITER_LOCK_EN
  task automatic test_lock();
    tb_lock = 1'b1;
    for (int n = 0; n < 10; n++) begin
      step(4'b0011);
      checks++;
      if (oGrant !== 4'b0001) begin
        failures++;
        $display("FAIL lock_hold cycle=%0d got=%b exp=0001", n, oGrant);
      end
    end
    tb_lock = 1'b0;
    step(4'b0011);
    checks++;
    if (oGrant !== 4'b0010) begin
      failures++;
      $display("FAIL lock_release got=%b exp=0010", oGrant);
    end
  endtask
`endif

  task automatic test_back_to_back();
    for (int n = 0; n < 40; n++) begin
`ifdef SEL_RR_ARBITER_LOCK_EN
      tb_lock = ($urandom_range(0, 3) == 0);
`endif
      step(4'($urandom_range(0, 15)));
    end
    tb_lock = 1'b0;
  endtask

  initial begin
    test_reset();
    test_first_grant();
    test_rotation();
    test_handover();
    test_sole_hold();
    test_async_reset();
`ifdef SEL_RR_ARBITER_LOCK_EN
    test_lock();
`endif
    test_back_to_back();
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL sb_drain got=%0d exp=0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
